// File: rtl/sky130_fd_io__amuxbus_arb.sv
// Arbiter and break-before-make sequencer for the two shared analog mux buses.
// Each bus runs an independent round-robin channel with make/settle and dead-time counting.

module sky130_fd_io__amuxbus_arb_chan #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAKE_CYC = 2,
  parameter int unsigned DEAD_CYC = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            bus_en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ena,
  output logic [NREQ-1:0] gnt,
  output logic            busy
);
  localparam int unsigned CNT_MAX = (MAKE_CYC > DEAD_CYC) ? MAKE_CYC : DEAD_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned OW      = $clog2(NREQ);
  localparam logic [CW-1:0] MAKE_LOAD = CW'(MAKE_CYC - 1);
  localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAKE, S_OWN, S_BREAK} state_t;

  state_t        state;
  logic [OW-1:0] owner;
  logic [OW-1:0] ptr;
  logic [OW-1:0] win;
  logic [OW-1:0] idx;
  logic [CW-1:0] cnt;
  logic          found;
  logic          keep;

  // First set request scanning ptr, ptr+1, ... wrapping at NREQ.
  always_comb begin
    win   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = OW'((32'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign keep = bus_en && req[owner];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      owner <= '0;
      ptr   <= '0;
      cnt   <= '0;
      ena   <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus_en && found) begin
            owner <= win;
            ena   <= NREQ'(1) << win;
            cnt   <= MAKE_LOAD;
            busy  <= 1'b1;
            state <= S_MAKE;
          end
        end
        S_MAKE, S_OWN: begin
          if (!keep) begin
            ena   <= '0;
            gnt   <= '0;
            cnt   <= DEAD_LOAD;
            ptr   <= (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);
            state <= S_BREAK;
          end else if (state == S_MAKE) begin
            if (cnt == '0) begin
              gnt   <= NREQ'(1) << owner;
              state <= S_OWN;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
        end
        S_BREAK: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

module sky130_fd_io__amuxbus_arb #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned MAKE_CYC = 2,
  parameter int unsigned DEAD_CYC = 4
) (
  input  logic            CLK,
  input  logic            RESET_B,
  input  logic            BUS_EN,
  input  logic [NREQ-1:0] REQ_A,
  input  logic [NREQ-1:0] REQ_B,
  output logic [NREQ-1:0] ENA_A,
  output logic [NREQ-1:0] ENA_B,
  output logic [NREQ-1:0] GNT_A,
  output logic [NREQ-1:0] GNT_B,
  output logic            BUSY_A,
  output logic            BUSY_B
);
  sky130_fd_io__amuxbus_arb_chan #(
    .NREQ(NREQ), .MAKE_CYC(MAKE_CYC), .DEAD_CYC(DEAD_CYC)
  ) u_chan_a (
    .clk(CLK), .rst_n(RESET_B), .bus_en(BUS_EN), .req(REQ_A),
    .ena(ENA_A), .gnt(GNT_A), .busy(BUSY_A)
  );

  sky130_fd_io__amuxbus_arb_chan #(
    .NREQ(NREQ), .MAKE_CYC(MAKE_CYC), .DEAD_CYC(DEAD_CYC)
  ) u_chan_b (
    .clk(CLK), .rst_n(RESET_B), .bus_en(BUS_EN), .req(REQ_B),
    .ena(ENA_B), .gnt(GNT_B), .busy(BUSY_B)
  );
endmodule

// File: tb/tb_sky130_fd_io__amuxbus_arb.sv
// Directed bench for sky130_fd_io__amuxbus_arb with NREQ=4, MAKE_CYC=2, DEAD_CYC=4.
module tb_sky130_fd_io__amuxbus_arb;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       bus_en;
  logic [3:0] req_a, req_b;
  logic [3:0] ena_a, ena_b, gnt_a, gnt_b;
  logic       busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  sky130_fd_io__amuxbus_arb #(.NREQ(4), .MAKE_CYC(2), .DEAD_CYC(4)) dut (
    .CLK(clk), .RESET_B(rst_n), .BUS_EN(bus_en),
    .REQ_A(req_a), .REQ_B(req_b),
    .ENA_A(ena_a), .ENA_B(ena_b), .GNT_A(gnt_a), .GNT_B(gnt_b),
    .BUSY_A(busy_a), .BUSY_B(busy_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sample and drive 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ena_a"}, ena_a, 0);
    chk({tag, "_gnt_a"}, gnt_a, 0);
    chk({tag, "_ena_b"}, ena_b, 0);
    chk({tag, "_gnt_b"}, gnt_b, 0);
    chk({tag, "_busy"}, {busy_a, busy_b}, 0);
  endtask

  initial begin
    int gap;
    int wait_cyc;
    int exp_owner [5] = '{0, 1, 2, 3, 0};
    logic [3:0] one;

    rst_n = 1'b0; bus_en = 1'b1; req_a = '0; req_b = '0;
    tick(2);
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick();
    chk_all_zero("idle");

    // Single request: owner 0 on A, B untouched
    req_a = 4'b0001;
    tick();
    chk("s_ena0", ena_a, 4'b0001);
    chk("s_gnt0", gnt_a, 4'b0000);
    chk("s_busy0", busy_a, 1'b1);
    chk("s_b_ena", ena_b, 4'b0000);
    chk("s_b_busy", busy_b, 1'b0);
    tick();
    chk("s_gnt1", gnt_a, 4'b0000);
    tick();
    chk("s_gnt2", gnt_a, 4'b0001);
    chk("s_ena2", ena_a, 4'b0001);

    // Release with requester 2 pending; PTR becomes 1
    req_a = 4'b0101;
    tick();
    chk("r_hold", gnt_a, 4'b0001);
    req_a = 4'b0100;
    tick();
    chk("r_ena", ena_a, 4'b0000);
    chk("r_gnt", gnt_a, 4'b0000);
    chk("r_busy", busy_a, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("r_dead%0d", i), ena_a, 4'b0000);
    end
    chk("r_busy_low", busy_a, 1'b0);
    tick();
    chk("r_ena_new", ena_a, 4'b0100);
    tick();
    chk("r_gnt_early", gnt_a, 4'b0000);
    tick();
    chk("r_gnt_new", gnt_a, 4'b0100);
    req_a = '0;
    tick(5);
    chk("r_idle", busy_a, 1'b0);

    // Abort in MAKE: PTR=3, requester 1 wins, drops before grant
    req_a = 4'b0010;
    tick();
    chk("ab_ena", ena_a, 4'b0010);
    req_a = '0;
    tick();
    chk("ab_ena_off", ena_a, 4'b0000);
    chk("ab_gnt", gnt_a, 4'b0000);
    chk("ab_busy", busy_a, 1'b1);
    tick(4);
    chk("ab_idle", busy_a, 1'b0);
    chk("ab_nognt", gnt_a, 4'b0000);

    // BUS_EN drop during OWN on both buses (A ptr=2 -> 0, B ptr=0 -> 3)
    req_a = 4'b0001; req_b = 4'b1000;
    tick(3);
    chk("be_gnt_a", gnt_a, 4'b0001);
    chk("be_gnt_b", gnt_b, 4'b1000);
    bus_en = 1'b0;
    tick();
    chk("be_ena", {ena_a, ena_b}, 8'h00);
    chk("be_gnt", {gnt_a, gnt_b}, 8'h00);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("be_busy%0d", i), {busy_a, busy_b}, 2'b11);
      tick();
    end
    chk("be_busy_low", {busy_a, busy_b}, 2'b00);
    tick(2);
    chk("be_no_regrant", {ena_a, ena_b, busy_a, busy_b}, 10'h000);
    bus_en = 1'b1; req_a = '0; req_b = '0;
    tick();

    // Independence: both buses pick requester 2 (A ptr=1, B ptr=0)
    req_a = 4'b0100; req_b = 4'b0100;
    tick();
    chk("ind_ena", {ena_a, ena_b}, 8'h44);
    tick();
    chk("ind_gnt_early", {gnt_a, gnt_b}, 8'h00);
    tick();
    chk("ind_gnt", {gnt_a, gnt_b}, 8'h44);

    // Async reset mid-OWN, between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("ar");
    req_a = 4'b1111; req_b = '0;
    tick();
    chk_all_zero("ar_held");
    rst_n = 1'b1;

    // Round robin from PTR=0 with all requesters continuously pending
    for (int n = 0; n < 5; n++) begin
      one = 4'b0001 << exp_owner[n];
      wait_cyc = 0;
      while (ena_a == '0 && wait_cyc < 20) begin
        tick();
        wait_cyc++;
      end
      chk($sformatf("rr%0d_ena", n), ena_a, one);
      chk($sformatf("rr%0d_onehot", n), $onehot0(ena_a), 1);
      tick(2);
      chk($sformatf("rr%0d_gnt", n), gnt_a, one);
      req_a = req_a & ~one;
      tick();
      chk($sformatf("rr%0d_rel", n), ena_a, 4'b0000);
      req_a = 4'b1111;
      if (n < 4) begin
        gap = 1;
        while (ena_a == '0 && gap < 20) begin
          tick();
          if (ena_a == '0) gap++;
        end
        chk($sformatf("rr%0d_gap", n), gap, 5);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sky130_fd_io__amuxbus_arb.md
# sky130_fd_io__amuxbus_arb

Clocked arbiter and break-before-make sequencer for the two shared analog mux buses (AMUXBUS_A, AMUXBUS_B) that run through the I/O ring, including the power pads.

- Each bus is shared among NREQ analog requesters, such as GPIO analog paths and core analog blocks.
- The block grants each bus to at most one requester at a time and drives the per-requester connection enables.
- It enforces a settle time after connection and a dead time after disconnection, so two sources are never shorted on a bus.

## Interface
Parameters:
- NREQ, 4: number of requesters per bus; legal range 2..16.
- MAKE_CYC, 2: cycles between connection enable rising and grant rising; minimum 1.
- DEAD_CYC, 4: break dead-time count; minimum 1.

Ports:
- CLK  input  1  block clock; one clock.
- RESET_B  input  1  reset, asynchronous and active-low.
- BUS_EN  input  1  global enable; low forces both buses to disconnect.
- REQ_A  input  NREQ  bit i: requester i wants AMUXBUS_A; level-sensitive, held high while needed.
- REQ_B  input  NREQ  the same, for AMUXBUS_B.
- ENA_A  output  NREQ  bit i: drive the switch connecting requester i to AMUXBUS_A; one-hot or zero.
- ENA_B  output  NREQ  the same, for AMUXBUS_B.
- GNT_A  output  NREQ  bit i: requester i owns AMUXBUS_A and the bus has settled; one-hot or zero.
- GNT_B  output  NREQ  the same, for AMUXBUS_B.
- BUSY_A  output  1  high whenever channel A is not in IDLE.
- BUSY_B  output  1  the same, for channel B.

## Operation
- Two identical, fully independent channels, A and B. One requester may own both buses at once.
- Each channel has a 2-bit state, an owner index, a round-robin pointer PTR and a down-counter CNT.
- CNT width is clog2(max(MAKE_CYC, DEAD_CYC)+1).
- All outputs are registered.
- Reset (RESET_B low, asynchronous) puts every channel in this state: IDLE, PTR=0, CNT=0, owner=0, ENA/GNT all 0, BUSY 0.

States:
- IDLE: when BUS_EN=1 and REQ≠0, pick the winner: the first set REQ bit scanning PTR, PTR+1, … mod NREQ. Then owner←winner, ENA[winner]←1, CNT←MAKE_CYC-1, go to MAKE. Otherwise stay in IDLE.
- MAKE: if REQ[owner]=0 or BUS_EN=0, go to BREAK. Otherwise, if CNT=0, set GNT[owner]←1 and go to OWN; else CNT←CNT-1.
- OWN: hold ENA and GNT. When REQ[owner]=0 or BUS_EN=0, go to BREAK. There is no preemption; other requests wait.
- BREAK entry, from MAKE or OWN: ENA←0, GNT←0, CNT←DEAD_CYC-1, PTR←(owner+1) mod NREQ.
- BREAK: if CNT=0, go to IDLE; else CNT←CNT-1. Requests are ignored.
- Requests that arrive during MAKE, OWN or BREAK stay pending. They are evaluated in IDLE with the updated PTR.
- The owner's REQ dropping and another REQ rising in the same cycle: normal BREAK. The new requester wins arbitration after the dead time.
- BUS_EN falling in IDLE: no effect. BUS_EN low in MAKE or OWN: BREAK on the next edge.
- RESET_B asserted mid-MAKE or mid-OWN: ENA and GNT clear immediately (asynchronously); no dead time is applied.

Invariants, on every cycle:
- ENA_x and GNT_x are each one-hot or zero.
- GNT_x is a subset of ENA_x.
- GNT_x[i]=1 implies the channel is in OWN.

## Timing
- Edges are numbered from the edge that samples the request in IDLE (edge 0).
- Request to ENA: ENA rises on edge 0, so it is visible 1 cycle after REQ is sampled.
- ENA to GNT: GNT rises exactly MAKE_CYC edges after ENA.
- Release: the edge that samples REQ[owner]=0 clears ENA and GNT together. Latency is 1 cycle.
- Break-before-make: from ENA falling to the next ENA rising on the same channel is at least DEAD_CYC+1 cycles.
- BUSY_x rises on the same edge as ENA rises. It falls on the edge where BREAK exits to IDLE.
- Back-to-back service of a continuously pending second requester: a new owner every (ownership duration + DEAD_CYC + 1) cycles.

## Test plan
Use NREQ=4, MAKE_CYC=2, DEAD_CYC=4.

- Single request: REQ_A=0001 from edge 0 → ENA_A=0001 after edge 0; GNT_A=0001 after edge 2; channel B untouched.
- Release and dead time: REQ_A[0] drops while REQ_A[2] is pending → ENA_A/GNT_A go to 0 on the next edge; ENA_A stays 0 for 5 cycles; then ENA_A=0100, and GNT_A=0100 two edges later.
- Round robin: REQ_A=1111 held, each owner dropping after its grant → owners appear in the order 0,1,2,3,0. ENA_A is never multi-hot, and there is a gap of at least 5 cycles between owners.
- Abort in MAKE and BUS_EN: REQ_A[1] drops the cycle after ENA_A=0010 → BREAK with no GNT pulse. BUS_EN=0 during OWN on both buses → both channels break next edge, and BUSY stays high for 4 further edges.
- Independence: REQ_A=REQ_B=0100 simultaneously → both channels grant requester 2 with identical timing.
- Async reset: RESET_B pulsed low mid-OWN between clock edges → all outputs 0 immediately. After release, the channel starts in IDLE with PTR=0.
